alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle execute controller for the 16-bit S-Machine datapath, sitting between instruction fetch and the combinational ALU. It accepts one instruction per handshake and owns the 8×16 general register file and the Z/N/C status register (PSW). It reads the operand registers, drives the ALU inputs, then writes the ALU results and status outputs back to the register file and PSW. It is the control-side counterpart of the ALU: it produces everything the ALU consumes and consumes everything the ALU produces.

## Interface
- NUM_REGS, 8: general registers; the index width is 3 bits, fixed.
- WIDTH, 16: data width, fixed by the ISA.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_valid  in  1  fetch presents an instruction.
- inst_ready  out  1  sequencer can accept (high only in IDLE with no load).
- inst  in  16  instruction word: [15:12] opcode, [10:8] Z/N/C mask, [5:3] B index, [2:0] A index.
- ld_valid  in  1  host register preload strobe.
- ld_addr  in  3  preload index.
- ld_data  in  16  preload value.
- alu_inst  out  16  latched instruction to ALU.
- alu_a, alu_b  out  16  operand A/B register contents.
- alu_z, alu_n, alu_c  out  1  current PSW bits to ALU.
- alu_a_res, alu_b_res  in  16  ALU register results.
- alu_z_res, alu_n_res, alu_c_res  in  1  ALU status results.
- done  out  1  one-cycle pulse on retire.
- illegal  out  1  one-cycle pulse, coincident with done, for non-ALU opcodes.
- psw  out  3  {Z,N,C}.
- dbg_addr  in  3  / dbg_data  out  16  combinational register-file read port.

## Operation
- FSM states: IDLE → ISSUE → CAPTURE → WRITE → IDLE.
- IDLE: ld_valid writes ld_data to reg[ld_addr], and inst_ready is low that cycle. Loads have priority over instructions. Otherwise, inst_valid&&inst_ready latches inst and goes to ISSUE.
- ISSUE: drive alu_a=reg[A], alu_b=reg[B], alu_inst=latched inst, and alu_z/n/c=PSW. These remain stable through CAPTURE.
- CAPTURE: register all five ALU result signals into holding registers.
- WRITE: apply writeback by opcode, pulse done, then return to IDLE.
  - 0100–1000 (ADD, SUB, OR, AND, XOR), 1001 (SHR): reg[A]←a_res; PSW←{z,n,c}_res.
  - 1010 MOV: reg[B]←b_res; PSW unchanged.
  - 1011 EXCH: reg[A]←a_res, reg[B]←b_res; when A==B, the A write wins.
  - 1100 CMP: PSW←{z,n,c}_res; no register write.
  - 1101 SET / 1110 CLR: PSW←{z,n,c}_res; no register write.
  - 0000–0011, 1111: no register or PSW change; illegal pulses.
- ld_valid outside IDLE is ignored (dropped, no error).
- alu_inst is held at 16'h0000 in IDLE so the ALU sits in its pass-through default.

## Timing
- Reset (synchronous): state=IDLE, all registers=0, PSW=3'b000, alu_inst/alu_a/alu_b=0, done=0, illegal=0. inst_ready goes high on the first cycle after reset deasserts.
- Reset asserted in any state abandons the in-flight instruction with no writeback and no done.
- Latency: with acceptance at edge 0, the ALU is driven from cycle 1, results are captured at edge 2, and writeback plus done occur at edge 3. Peak throughput is one instruction per 4 cycles.
- inst_ready is combinational from state and ld_valid. Fetch must hold inst stable while valid&&!ready.
- An instruction accepted in the cycle after done sees the updated registers and PSW (no forwarding needed).
- dbg_data reflects a write on the cycle after the write edge.

## Structure
- Shared package `smachine_pkg` holds:
  - opcode localparams OP_ADD=4'b0100 … OP_CLR=4'b1110;
  - state enum {IDLE, ISSUE, CAPTURE, WRITE};
  - field-slice constants for opcode, mask, A index and B index.
- One sub-module, `regfile8x16`: 8×16, one synchronous write port, and three combinational read ports (A, B, dbg). Its two writes are merged by the sequencer, with A priority.
- The ALU stays external and is instantiated alongside this block at the top level.

## Test plan
- Preload r1=16'h0005, r2=16'h0003; issue ADD (A=1, B=2) with the ALU model returning 16'h0008, z=0, n=0, c=0 → done at edge 3, r1=16'h0008, psw=000.
- Issue EXCH A=3, B=4 with r3=16'hAAAA, r4=16'h5555 → r3=16'h5555, r4=16'hAAAA, PSW unchanged. Repeat with A=B=3 → r3 is unchanged.
- Issue CMP with the ALU returning z=1 → psw=3'b100 and no register changes. Issue SET with mask 3'b011 → psw=3'b111.
- Assert ld_valid and inst_valid together in IDLE → the load is applied, inst_ready=0, and the instruction is accepted the next cycle.
- Issue opcode 4'b1111 → done and illegal pulse together; registers and PSW are unchanged.
- Assert rst during CAPTURE of an ADD → no done pulse, all registers 0, and inst_ready=1 on the cycle after rst falls.

Source files
------------

// File: rtl/smachine_pkg.sv
// Shared definitions for the S-Machine execute path: opcodes, FSM states,
// instruction field slices and the writeback decode.
package smachine_pkg;

  localparam int IDX_W = 3;

  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_EXCH = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_SET  = 4'b1101;
  localparam logic [3:0] OP_CLR  = 4'b1110;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int MASK_MSB = 10;
  localparam int MASK_LSB = 8;
  localparam int B_MSB    = 5;
  localparam int B_LSB    = 3;
  localparam int A_MSB    = 2;
  localparam int A_LSB    = 0;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WRITE} state_t;

  typedef struct packed {
    logic wr_a;
    logic wr_b;
    logic wr_psw;
    logic illegal;
  } wb_ctl_t;

  function automatic logic [3:0] inst_opc(input logic [15:0] i);
    return i[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [IDX_W-1:0] inst_a_idx(input logic [15:0] i);
    return i[A_MSB:A_LSB];
  endfunction

  function automatic logic [IDX_W-1:0] inst_b_idx(input logic [15:0] i);
    return i[B_MSB:B_LSB];
  endfunction

  // Which state each opcode is allowed to modify when it retires.
  function automatic wb_ctl_t wb_decode(input logic [3:0] opc);
    wb_ctl_t c;
    c = '0;
    case (opc)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_SHR: begin
        c.wr_a   = 1'b1;
        c.wr_psw = 1'b1;
      end
      OP_MOV:  c.wr_b = 1'b1;
      OP_EXCH: begin
        c.wr_a = 1'b1;
        c.wr_b = 1'b1;
      end
      OP_CMP, OP_SET, OP_CLR: c.wr_psw = 1'b1;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/regfile8x16.sv
// General register file: two write channels merged into one write process
// (A channel wins on a shared index) and three combinational read ports.
module regfile8x16
  import smachine_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_a,
  input  logic [IDX_W-1:0] wa_addr,
  input  logic [WIDTH-1:0] wa_data,
  input  logic             we_b,
  input  logic [IDX_W-1:0] wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [IDX_W-1:0] ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [IDX_W-1:0] rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [NUM_REGS];

  // B is written first so that an A write to the same index overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      if (we_b) r_mem[wb_addr] <= wb_data;
      if (we_a) r_mem[wa_addr] <= wa_data;
    end
  end

  assign ra_data = r_mem[ra_addr];
  assign rb_data = r_mem[rb_addr];
  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute controller: latches one instruction, drives the external
// ALU from the register file and PSW, then retires its results.
module alu_sequencer
  import smachine_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [15:0]      inst,
  input  logic             ld_valid,
  input  logic [IDX_W-1:0] ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [15:0]      alu_inst,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_z,
  output logic             alu_n,
  output logic             alu_c,
  input  logic [WIDTH-1:0] alu_a_res,
  input  logic [WIDTH-1:0] alu_b_res,
  input  logic             alu_z_res,
  input  logic             alu_n_res,
  input  logic             alu_c_res,
  output logic             done,
  output logic             illegal,
  output logic [2:0]       psw,
  input  logic [IDX_W-1:0] dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic [15:0]      r_inst;
  logic [WIDTH-1:0] r_a_res;
  logic [WIDTH-1:0] r_b_res;
  logic [2:0]       r_znc_res;
  logic [2:0]       r_psw;
  logic             r_done;
  logic             r_illegal;
  wb_ctl_t          w_wb;
  logic             w_in_write;
  logic             w_active;
  logic             w_we_a;
  logic [IDX_W-1:0] w_wa_addr;
  logic [WIDTH-1:0] w_wa_data;
  logic             w_we_b;
  logic [WIDTH-1:0] w_ra_data;
  logic [WIDTH-1:0] w_rb_data;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A host load in IDLE takes the cycle, so the instruction waits one more.
  always_comb begin
    w_next     = r_state;
    inst_ready = 1'b0;
    case (r_state)
      IDLE: begin
        inst_ready = !ld_valid;
        if (inst_valid && !ld_valid) w_next = ISSUE;
      end
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = WRITE;
      WRITE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_accept   = inst_valid && inst_ready;
  assign w_in_write = (r_state == WRITE);
  assign w_active   = (r_state != IDLE);
  assign w_wb       = wb_decode(inst_opc(r_inst));

  always_ff @(posedge clk) begin
    if (rst)           r_inst <= '0;
    else if (w_accept) r_inst <= inst;
  end

  // ALU outputs are held here so writeback sees a stable snapshot.
  always_ff @(posedge clk) begin
    if (r_state == CAPTURE) begin
      r_a_res   <= alu_a_res;
      r_b_res   <= alu_b_res;
      r_znc_res <= {alu_z_res, alu_n_res, alu_c_res};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_psw     <= 3'b000;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if (w_in_write && w_wb.wr_psw) r_psw <= r_znc_res;
      r_done    <= w_in_write;
      r_illegal <= w_in_write && w_wb.illegal;
    end
  end

  // The A channel carries host loads in IDLE and A writeback in WRITE.
  always_comb begin
    w_we_a    = 1'b0;
    w_wa_addr = ld_addr;
    w_wa_data = ld_data;
    if (r_state == IDLE) begin
      w_we_a = ld_valid;
    end else if (w_in_write) begin
      w_we_a    = w_wb.wr_a;
      w_wa_addr = inst_a_idx(r_inst);
      w_wa_data = r_a_res;
    end
  end

  assign w_we_b = w_in_write && w_wb.wr_b;

  regfile8x16 #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we_a    (w_we_a),
    .wa_addr (w_wa_addr),
    .wa_data (w_wa_data),
    .we_b    (w_we_b),
    .wb_addr (inst_b_idx(r_inst)),
    .wb_data (r_b_res),
    .ra_addr (inst_a_idx(r_inst)),
    .ra_data (w_ra_data),
    .rb_addr (inst_b_idx(r_inst)),
    .rb_data (w_rb_data),
    .rd_addr (dbg_addr),
    .rd_data (dbg_data)
  );

  assign alu_inst = w_active ? r_inst    : 16'h0000;
  assign alu_a    = w_active ? w_ra_data : '0;
  assign alu_b    = w_active ? w_rb_data : '0;
  assign alu_z    = r_psw[2];
  assign alu_n    = r_psw[1];
  assign alu_c    = r_psw[0];
  assign psw      = r_psw;
  assign done     = r_done;
  assign illegal  = r_illegal;

endmodule
